// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS multiply/divide unit: operation codes,
// FSM state encoding, iteration count and a small negation helper.
package mips_pkg;

    // Number of shift-add / restoring-divide iterations for a 32-bit datapath
    localparam int MULDIV_ITERS = 32;

    // Operation select driven by the control unit; 110/111 are reserved
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101
    } muldiv_op_t;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        MUL  = 2'b01,
        DIV  = 2'b10,
        FIX  = 2'b11
    } muldiv_state_t;

    // Two's-complement negate when 'neg' is set, pass-through otherwise
    function automatic logic [31:0] negIf(input logic neg, input logic [31:0] v);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mips_muldiv_if.sv
// Request/result bundle between the execute-stage control and the
// multiply/divide unit. The master issues requests, the slave owns HI/LO.
interface mips_muldiv_if;

    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, hi, lo
    );

endinterface

// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO pair. Multiplies use a
// radix-2 shift-add over a shared 64-bit accumulator; divides use restoring
// division on the same accumulator. Signed operands are reduced to magnitudes
// on entry and the result signs are applied in a final FIX cycle.
module mips_muldiv
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    mips_muldiv_if.slave bus
);

    muldiv_state_t state_q, state_d;
    logic [5:0]    cnt_q, cnt_d;
    logic [63:0]   acc_q, acc_d;
    logic [31:0]   aMag_q, aMag_d;
    logic [31:0]   bMag_q, bMag_d;
    logic [31:0]   hi_q, hi_d;
    logic [31:0]   lo_q, lo_d;
    logic          quotNeg_q, quotNeg_d;
    logic          remNeg_q, remNeg_d;
    logic          isDiv_q, isDiv_d;
    logic          divZero_q, divZero_d;
    logic          done_q, done_d;

    logic          signedOp;
    logic [31:0]   aMagIn;
    logic [31:0]   bMagIn;
    logic [32:0]   mulSum;
    logic [32:0]   remShift;
    logic          divGe;
    logic [31:0]   remDiff;
    logic [63:0]   product;
    logic          lastIter;

    assign signedOp = (bus.op == OP_MULT) || (bus.op == OP_DIV);
    assign aMagIn   = negIf(signedOp & bus.src_a[31], bus.src_a);
    assign bMagIn   = negIf(signedOp & bus.src_b[31], bus.src_b);

    // Upper product half plus multiplicand, carry kept for the right shift
    assign mulSum   = {1'b0, acc_q[63:32]} + {1'b0, aMag_q};

    // Partial remainder shifted left with the next dividend bit brought in
    assign remShift = acc_q[63:31];
    assign divGe    = remShift >= {1'b0, bMag_q};
    // When the trial subtract succeeds the difference is below the divisor,
    // so the low 32 bits are the whole new remainder
    assign remDiff  = remShift[31:0] - bMag_q;

    assign product  = quotNeg_q ? (~acc_q + 64'd1) : acc_q;
    assign lastIter = (cnt_q == 6'(MULDIV_ITERS - 1));

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

    // State and datapath registers; reset clears the FSM, HI/LO and done
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            acc_q     <= '0;
            aMag_q    <= '0;
            bMag_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            quotNeg_q <= 1'b0;
            remNeg_q  <= 1'b0;
            isDiv_q   <= 1'b0;
            divZero_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            acc_q     <= acc_d;
            aMag_q    <= aMag_d;
            bMag_q    <= bMag_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            quotNeg_q <= quotNeg_d;
            remNeg_q  <= remNeg_d;
            isDiv_q   <= isDiv_d;
            divZero_q <= divZero_d;
            done_q    <= done_d;
        end
    end

    // Next-state and datapath update; requests are only looked at in IDLE
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        acc_d     = acc_q;
        aMag_d    = aMag_q;
        bMag_d    = bMag_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        quotNeg_d = quotNeg_q;
        remNeg_d  = remNeg_q;
        isDiv_d   = isDiv_q;
        divZero_d = divZero_q;
        done_d    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            state_d   = MUL;
                            cnt_d     = '0;
                            acc_d     = {32'd0, bMagIn};
                            aMag_d    = aMagIn;
                            bMag_d    = bMagIn;
                            quotNeg_d = signedOp & (bus.src_a[31] ^ bus.src_b[31]);
                            remNeg_d  = signedOp & bus.src_a[31];
                            isDiv_d   = 1'b0;
                            divZero_d = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d   = DIV;
                            cnt_d     = '0;
                            acc_d     = {32'd0, aMagIn};
                            aMag_d    = aMagIn;
                            bMag_d    = bMagIn;
                            quotNeg_d = signedOp & (bus.src_a[31] ^ bus.src_b[31]);
                            remNeg_d  = signedOp & bus.src_a[31];
                            isDiv_d   = 1'b1;
                            divZero_d = (bus.src_b == 32'd0);
                        end
                        OP_MTHI: hi_d = bus.src_a;
                        OP_MTLO: lo_d = bus.src_a;
                        default: ;
                    endcase
                end
            end

            MUL: begin
                acc_d = acc_q[0] ? {mulSum, acc_q[31:1]} : {1'b0, acc_q[63:1]};
                cnt_d = cnt_q + 6'd1;
                if (lastIter) begin
                    state_d = FIX;
                end
            end

            DIV: begin
                acc_d = {divGe ? remDiff : remShift[31:0], acc_q[30:0], divGe};
                cnt_d = cnt_q + 6'd1;
                if (lastIter) begin
                    state_d = FIX;
                end
            end

            FIX: begin
                if (!isDiv_q) begin
                    hi_d = product[63:32];
                    lo_d = product[31:0];
                end else if (divZero_q) begin
                    // Restoring the sign of the stored magnitude recovers the raw dividend
                    hi_d = negIf(remNeg_q, aMag_q);
                    lo_d = 32'hFFFF_FFFF;
                end else begin
                    hi_d = negIf(remNeg_q, acc_q[63:32]);
                    lo_d = negIf(quotNeg_q, acc_q[31:0]);
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed self-checking bench for mips_muldiv. Expected HI/LO values come
// from a behavioural arithmetic model and travel through a scoreboard queue
// from the moment a request is issued until the unit reports completion.
module tb_mips_muldiv;
    import mips_pkg::*;

    typedef struct {
        string       tag;
        logic [31:0] hi;
        logic [31:0] lo;
    } sbEntry_t;

    logic clk;
    logic reset;

    mips_muldiv_if bus();

    mips_muldiv dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          vectors     = 0;
    int          miscompares = 0;
    int          edgeCount   = 0;
    logic [31:0] modelHi     = 32'd0;
    logic [31:0] modelLo     = 32'd0;
    sbEntry_t    sbQ[$];

    // Free-running clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising-edge counter used to measure request-to-done latency
    always @(posedge clk) edgeCount <= edgeCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Behavioural HI/LO result for one operation
    task automatic modelOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           output logic [31:0] eHi, output logic [31:0] eLo);
        longint p;
        int     sa;
        int     sb;
        eHi = modelHi;
        eLo = modelLo;
        case (op)
            OP_MULT: begin
                p   = longint'($signed(a)) * longint'($signed(b));
                eHi = p[63:32];
                eLo = p[31:0];
            end
            OP_MULTU: begin
                p   = longint'({32'd0, a}) * longint'({32'd0, b});
                eHi = p[63:32];
                eLo = p[31:0];
            end
            OP_DIV: begin
                if (b == 32'd0) begin
                    eHi = a;
                    eLo = 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    eHi = 32'd0;
                    eLo = 32'h8000_0000;
                end else begin
                    sa  = a;
                    sb  = b;
                    eLo = 32'(sa / sb);
                    eHi = 32'(sa % sb);
                end
            end
            OP_DIVU: begin
                if (b == 32'd0) begin
                    eHi = a;
                    eLo = 32'hFFFF_FFFF;
                end else begin
                    eLo = a / b;
                    eHi = a % b;
                end
            end
            OP_MTHI: eHi = a;
            OP_MTLO: eLo = a;
            default: ;
        endcase
    endtask

    // One-cycle request pulse, driven and released on falling edges
    task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.start = 1'b1;
        bus.op    = op;
        bus.src_a = a;
        bus.src_b = b;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // Wait (bounded) for done, then compare against the scoreboard head
    task automatic waitDone(input string tag, input int startEdge);
        int       cycles = 0;
        sbEntry_t exp;
        checkOutput({tag, "/holdHi"}, bus.hi, modelHi);
        checkOutput({tag, "/holdLo"}, bus.lo, modelLo);
        while (bus.done !== 1'b1 && cycles < 60) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput({tag, "/doneSeen"}, 32'(bus.done), 32'd1);
        checkOutput({tag, "/busyCycles"}, 32'(edgeCount - startEdge), 32'd33);
        checkOutput({tag, "/busyLow"}, 32'(bus.busy), 32'd0);
        if (sbQ.size() == 0) begin
            checkOutput({tag, "/sbEmpty"}, 32'(sbQ.size()), 32'd1);
        end else begin
            exp = sbQ.pop_front();
            checkOutput({exp.tag, "/hi"}, bus.hi, exp.hi);
            checkOutput({exp.tag, "/lo"}, bus.lo, exp.lo);
            modelHi = exp.hi;
            modelLo = exp.lo;
        end
        @(negedge clk);
        checkOutput({tag, "/donePulse"}, 32'(bus.done), 32'd0);
    endtask

    task automatic runMulDiv(input string tag, input logic [2:0] op,
                             input logic [31:0] a, input logic [31:0] b);
        sbEntry_t e;
        int       startEdge;
        e.tag = tag;
        modelOp(op, a, b, e.hi, e.lo);
        sbQ.push_back(e);
        applyStimulus(op, a, b);
        startEdge = edgeCount;
        waitDone(tag, startEdge);
    endtask

    // MTHI/MTLO/reserved: result visible the cycle after the request edge
    task automatic runMove(input string tag, input logic [2:0] op, input logic [31:0] a);
        sbEntry_t e;
        e.tag = tag;
        modelOp(op, a, 32'd0, e.hi, e.lo);
        sbQ.push_back(e);
        applyStimulus(op, a, 32'hA5A5_A5A5);
        e = sbQ.pop_front();
        checkOutput({tag, "/hi"}, bus.hi, e.hi);
        checkOutput({tag, "/lo"}, bus.lo, e.lo);
        checkOutput({tag, "/busy"}, 32'(bus.busy), 32'd0);
        modelHi = e.hi;
        modelLo = e.lo;
        @(negedge clk);
        checkOutput({tag, "/noDone"}, 32'(bus.done), 32'd0);
    endtask

    initial begin
        sbEntry_t e;
        int       startEdge;
        int       doneCount;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.src_a = 32'd0;
        bus.src_b = 32'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("reset/hi", bus.hi, 32'd0);
        checkOutput("reset/lo", bus.lo, 32'd0);
        checkOutput("reset/busy", 32'(bus.busy), 32'd0);
        checkOutput("reset/done", 32'(bus.done), 32'd0);

        runMulDiv("multuMax", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        runMulDiv("multNeg3x5", OP_MULT, 32'hFFFF_FFFD, 32'd5);
        runMulDiv("divNeg7by2", OP_DIV, 32'hFFFF_FFF9, 32'd2);
        runMulDiv("div7byNeg2", OP_DIV, 32'd7, 32'hFFFF_FFFE);
        runMulDiv("divMinByNeg1", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        runMulDiv("divu7by0", OP_DIVU, 32'd7, 32'd0);
        runMulDiv("divNeg5by0", OP_DIV, 32'hFFFF_FFFB, 32'd0);
        runMulDiv("multMinSq", OP_MULT, 32'h8000_0000, 32'h8000_0000);
        runMulDiv("multuMix", OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
        runMove("mthi", OP_MTHI, 32'hCAFE_F00D);
        runMove("reserved", 3'b110, 32'h0BAD_0BAD);
        runMove("mtlo", OP_MTLO, 32'h1234_5678);

        // DIVU 100/7 with an MTHI and a second request issued while busy
        e.tag = "divuBusyIgnore";
        modelOp(OP_DIVU, 32'd100, 32'd7, e.hi, e.lo);
        sbQ.push_back(e);
        applyStimulus(OP_DIVU, 32'd100, 32'd7);
        startEdge = edgeCount;
        repeat (3) @(negedge clk);
        applyStimulus(OP_MTHI, 32'h0000_DEAD, 32'd0);
        checkOutput("busyMthi/hi", bus.hi, modelHi);
        applyStimulus(OP_MULTU, 32'd5, 32'd6);
        checkOutput("busyStart/busy", 32'(bus.busy), 32'd1);
        waitDone("divuBusyIgnore", startEdge);

        // Reset during iteration 10 of DIV 1000/3
        applyStimulus(OP_DIV, 32'd1000, 32'd3);
        startEdge = edgeCount;
        while (edgeCount < startEdge + 9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset   = 1'b0;
        modelHi = 32'd0;
        modelLo = 32'd0;
        checkOutput("midReset/busy", 32'(bus.busy), 32'd0);
        checkOutput("midReset/done", 32'(bus.done), 32'd0);
        checkOutput("midReset/hi", bus.hi, modelHi);
        checkOutput("midReset/lo", bus.lo, modelLo);
        doneCount = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) doneCount++;
        end
        checkOutput("midReset/staleDone", 32'(doneCount), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
# mips_muldiv

Iterative multiply/divide unit that owns the HI/LO register pair for MULT, MULTU, DIV, DIVU, MTHI and MTLO. It sits beside the ALU in the execute stage. It accepts operands with a start pulse and holds `busy` while iterating. It presents `hi`/`lo` continuously to the downstream ALU result mux for MFHI/MFLO. The control unit stalls on `busy`.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request; sampled only when `busy`=0.
- `op`  in  3  encoding:
  - 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO.
  - 110/111 reserved; ignored.
- `src_a`  in  32  rs operand (multiplicand / dividend / MT source).
- `src_b`  in  32  rt operand (multiplier / divisor); unused for MTHI/MTLO.
- `busy`  out  1  high while a multiply/divide iterates.
- `done`  out  1  one-cycle pulse after HI/LO are written by a multiply/divide.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, MUL, DIV, FIX.
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0.
- IDLE, `start`=1:
  - MULT/MULTU → MUL.
  - DIV/DIVU → DIV.
  - MTHI → `hi`<=`src_a` and stay IDLE.
  - MTLO → `lo`<=`src_a` and stay IDLE.
  - Reserved op → no effect.
- Operand latch on entry to MUL or DIV:
  - Signed ops store the magnitudes of `src_a`/`src_b`, plus result sign flags.
  - Product/quotient sign = sign(a) XOR sign(b).
  - Remainder sign = sign(a).
  - Unsigned ops store the raw operands with both flags clear.
- MUL: radix-2 shift-add over the 64-bit product, one multiplier bit per cycle, 32 cycles, then → FIX.
- DIV: restoring division, one quotient bit per cycle, 32 cycles, then → FIX.
  - Uses a 33-bit partial remainder for the subtract.
- FIX, multiply:
  - 64-bit result negated if the sign flag is set.
  - `hi`<=[63:32], `lo`<=[31:0].
- FIX, divide:
  - Quotient and remainder negated per their flags.
  - `lo`<=quotient, `hi`<=remainder.
  - FIX → IDLE.
- Divide by zero (`src_b`=0, signed or unsigned):
  - Same latency; `hi`<=`src_a` unmodified, `lo`<=32'hFFFFFFFF.
  - Sign fix is suppressed.
- 0x80000000 / 0xFFFFFFFF (DIV): `lo`=0x80000000, `hi`=0. No trap.
- `start` while `busy`=1: ignored entirely, MTHI/MTLO included. Operands are not re-latched.
- `hi`/`lo` keep their old values during iteration; they change only at the FIX edge or an MT edge.

## Timing
- Start accepted at edge E0.
- `busy`=1 from after E0 through the cycle before E33. It deasserts in the same cycle `done` asserts.
- E1..E32: iterations. E33: FIX writes `hi`/`lo`, and `done`=1 for the cycle after E33.
- A new `start` is accepted at E34 at the earliest, i.e. in the cycle `done`=1.
- Multiply/divide latency is 34 edges from request edge to first edge that can observe `done`.
- MTHI/MTLO: `hi`/`lo` update at E0 and are visible the next cycle. No `busy`, no `done`.
- `reset` mid-operation wins over everything at that edge:
  - Next cycle: IDLE, `busy`=0, `done`=0, `hi`=`lo`=0.
  - No stale `done` appears later.
- Outputs are registered; `busy` is decoded from state, not from combinational inputs.

## Structure
- Shared package `mips_pkg` holds:
  - `muldiv_op_t` enum (the 3-bit op codes above).
  - `muldiv_state_t` enum (IDLE, MUL, DIV, FIX).
  - Constant `MULDIV_ITERS`=32.
- Single module, no sub-module.
- Iteration counter is 6 bits.
- MUL and DIV share the 64-bit accumulator and the operand registers.

## Test plan
- Reset held 2 cycles, then released → `hi`=0, `lo`=0, `busy`=0, `done`=0.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → `busy` high 33 cycles, one `done` pulse, `hi`=0xFFFFFFFE, `lo`=0x00000001.
- MULT 0xFFFFFFFD(−3)×5 → `hi`=0xFFFFFFFF, `lo`=0xFFFFFFF1.
- DIV 0xFFFFFFF9(−7)/2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF.
- DIVU 7/0 → `hi`=7, `lo`=0xFFFFFFFF.
- MTLO 0x12345678 in IDLE:
  - `lo`=0x12345678 next cycle, `busy` stays 0.
  - Then start DIVU 100/7; a MTHI 0xDEAD and a second start issued while busy → both ignored.
  - Result `lo`=14, `hi`=2.
- Reset asserted at iteration 10 of DIV 1000/3 → next cycle `busy`=0, `hi`=`lo`=0, and no `done` for the following 40 cycles.
